// File: rtl/modinv_keygen.sv
// modinv_keygen: RSA e/d generator, extended Euclid with a bit-serial divider and bounded candidate retries
// Ports: clk, rst_n (sync, active-low); start/phi request; rng_e candidate in, rng_en advance pulse out;
//        busy while a request runs; key_valid pulse with e_key/d_key; fail pulse when no key can be produced.
// Optional: define MODINV_KEYGEN_REJECT_SMALL_E_EN to reject e<3 and even e in LOAD (and phi<5 up front).
module modinv_keygen #(
  parameter int WIDTH = 32,
  parameter int MAX_TRIES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] phi,
  input  logic [WIDTH-1:0] rng_e,
  output logic             rng_en,
  output logic             busy,
  output logic             key_valid,
  output logic [WIDTH-1:0] e_key,
  output logic [WIDTH-1:0] d_key,
  output logic             fail
);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, UPDATE, DONE, FAIL} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] phi_r, e_r, r0, r1, rem;
  logic signed [WIDTH+1:0] t0, t1, prod;
  logic [CW-1:0] cnt;
  logic [7:0] tries;
  logic [WIDTH:0] sh;
  logic ge, e_bad, phi_bad, last_try, div_end;
  assign busy = state == LOAD || state == DIV || state == UPDATE;
  assign rng_en = state == LOAD;
  assign key_valid = state == DONE;
  assign fail = state == FAIL;
  // r0 doubles as the dividend shift register; after WIDTH steps it holds the quotient
  assign sh = {rem, r0[WIDTH-1]};
  assign ge = sh >= {1'b0, r1};
  assign prod = $signed({2'b00, r0}) * t1;
  assign last_try = tries == 8'(MAX_TRIES - 1);
  assign div_end = cnt == CW'(WIDTH - 1);
`ifdef MODINV_KEYGEN_REJECT_SMALL_E_EN
  assign phi_bad = phi < WIDTH'(5);
  assign e_bad = rng_e == '0 || rng_e >= phi_r || rng_e < WIDTH'(3) || !rng_e[0];
`else
  assign phi_bad = phi < WIDTH'(3);
  assign e_bad = rng_e == '0 || rng_e >= phi_r;
`endif
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // DONE/FAIL already have busy low, so a start there is accepted like in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, FAIL: state_nx = !start ? IDLE : phi_bad ? FAIL : LOAD;
      LOAD:             state_nx = !e_bad ? DIV : last_try ? FAIL : LOAD;
      DIV:              state_nx = div_end ? UPDATE : DIV;
      UPDATE:           state_nx = rem != '0 ? DIV : r1 == WIDTH'(1) ? DONE : last_try ? FAIL : LOAD;
      default:          state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi_r <= '0;
      e_r <= '0;
      r0 <= '0;
      r1 <= '0;
      rem <= '0;
      t0 <= '0;
      t1 <= '0;
      cnt <= '0;
      tries <= '0;
      e_key <= '0;
      d_key <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          tries <= '0;
          if (start) phi_r <= phi;
        end
        LOAD: begin
          e_r <= rng_e;
          r0 <= phi_r;
          r1 <= rng_e;
          t0 <= '0;
          t1 <= (WIDTH+2)'(1);
          rem <= '0;
          cnt <= '0;
          if (e_bad) tries <= tries + 8'd1;
        end
        DIV: begin
          rem <= ge ? WIDTH'(sh - {1'b0, r1}) : sh[WIDTH-1:0];
          r0 <= {r0[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        UPDATE: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= t0 - prod;
          rem <= '0;
          cnt <= '0;
          // zero remainder: old r1 is the gcd and old t1 the Bezout coefficient of e
          if (rem == '0 && r1 == WIDTH'(1)) begin
            e_key <= e_r;
            d_key <= t1[WIDTH+1] ? WIDTH'(t1 + $signed({2'b00, phi_r})) : t1[WIDTH-1:0];
          end
          if (rem == '0 && r1 != WIDTH'(1)) tries <= tries + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modinv_keygen.sv
// tb_modinv_keygen: vector table, reset sequences and randomized runs against a modular-inverse model
module tb_modinv_keygen;
  localparam int W = 32;
  localparam int MT = 255;
`ifdef MODINV_KEYGEN_REJECT_SMALL_E_EN
  localparam bit SMALL = 1;
  localparam longint PMIN = 5;
`else
  localparam bit SMALL = 0;
  localparam longint PMIN = 3;
`endif
  typedef struct {
    logic [31:0] phi;
    logic [31:0] s[3];
    int n;
    bit ok;
    logic [31:0] e;
    logic [31:0] d;
    int rng;
    int lat;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] phi = 0;
  logic [31:0] rng_e;
  logic rng_en, busy, key_valid, fail;
  logic [31:0] e_key, d_key;
  logic [31:0] seq_a[256];
  int seq_n = 1, pulses = 0, base = 0;
  int total = 0, bad = 0;
  longint held_e = 0, held_d = 0;
  logic [7:0] k8;
  vec_t v[9];
  always #5 clk = ~clk;
  modinv_keygen #(.WIDTH(W), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .phi(phi), .rng_e(rng_e), .rng_en(rng_en),
    .busy(busy), .key_valid(key_valid), .e_key(e_key), .d_key(d_key), .fail(fail)
  );
  // candidate source: steps through seq_a on each rng_en, repeating the last entry
  assign k8 = (pulses - base > seq_n - 1) ? 8'(seq_n - 1) : 8'(pulses - base);
  assign rng_e = seq_a[k8];
  always @(posedge clk) if (rng_en) begin
    #1;
    pulses++;
  end
  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  // reference: candidates in order, reject on range/gcd, inverse from Bezout coefficient
  function automatic void model(input longint p, output bit ok, output longint e, output longint d,
                                output int nc, output int lat);
    longint a, b, x0, x1, q, tmp, c;
    int steps;
    ok = 0; e = 0; d = 0; nc = 0; lat = 1;
    if (p < PMIN) return;
    for (int tr = 0; tr < MT; tr++) begin
      c = longint'(seq_a[tr < seq_n ? tr : seq_n - 1]);
      nc++;
      lat++;
      if (c == 0 || c >= p || (SMALL && (c < 3 || c % 2 == 0))) continue;
      a = p; b = c; x0 = 0; x1 = 1; steps = 1;
      while (a % b != 0) begin
        q = a / b;
        tmp = a % b; a = b; b = tmp;
        tmp = x0 - q * x1; x0 = x1; x1 = tmp;
        steps++;
      end
      lat += steps * (W + 1);
      if (b == 1) begin
        ok = 1; e = c; d = x1 < 0 ? x1 + p : x1;
        return;
      end
    end
  endfunction
  task automatic run_check(input longint p, input bit exp_ok, input longint exp_e, input longint exp_d,
                           input int exp_rng, input int exp_lat);
    int lat;
    bit got_ok, got_fail;
    longint unsigned pr, pu;
    @(negedge clk);
    phi = p[31:0]; start = 1; base = pulses;
    @(negedge clk);
    start = 0; lat = 1;
    while (!key_valid && !fail && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    got_ok = key_valid; got_fail = fail;
    chk("key_valid", longint'(got_ok), longint'(exp_ok));
    chk("fail", longint'(got_fail), longint'(!exp_ok));
    chk("latency", lat, exp_lat);
    chk("busy_end", longint'(busy), 0);
    chk("e_key", longint'(e_key), exp_ok ? exp_e : held_e);
    chk("d_key", longint'(d_key), exp_ok ? exp_d : held_d);
    chk("rng_en_pulses", pulses - base, exp_rng);
    if (exp_ok) begin
      held_e = exp_e; held_d = exp_d;
      pu = 64'(p);
      pr = 64'(e_key) * 64'(d_key);
      chk("inverse", longint'(pr % pu), 1);
    end
    @(negedge clk);
    chk("pulse_width", longint'(key_valid | fail), 0);
  endtask
  initial begin
    bit m_ok;
    longint m_e, m_d, p;
    int m_nc, m_lat, spur;
    v[0] = '{20, '{7, 0, 0}, 1, 1, 7, 3, 1, 101};
    v[1] = '{3120, '{17, 0, 0}, 1, 1, 17, 2753, 1, 134};
    v[3] = '{2, '{7, 0, 0}, 1, 0, 0, 0, 0, 1};
    v[4] = '{20, '{19, 0, 0}, 1, 1, 19, 19, 1, 68};
    v[8] = '{0, '{5, 0, 0}, 1, 0, 0, 0, 0, 1};
`ifdef MODINV_KEYGEN_REJECT_SMALL_E_EN
    v[2] = '{20, '{4, 25, 3}, 3, 1, 3, 7, 3, 103};
    v[5] = '{20, '{1, 2, 3}, 3, 1, 3, 7, 3, 103};
    v[6] = '{3, '{2, 0, 0}, 1, 0, 0, 0, 0, 1};
    v[7] = '{20, '{10, 0, 0}, 1, 0, 0, 0, 255, 256};
`else
    v[2] = '{20, '{4, 25, 3}, 3, 1, 3, 7, 3, 136};
    v[5] = '{20, '{1, 2, 3}, 3, 1, 1, 1, 1, 35};
    v[6] = '{3, '{2, 0, 0}, 1, 1, 2, 2, 1, 68};
    v[7] = '{20, '{10, 0, 0}, 1, 0, 0, 0, 255, 8671};
`endif
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_rng_en", longint'(rng_en), 0);
    chk("reset_key_valid", longint'(key_valid), 0);
    chk("reset_fail", longint'(fail), 0);
    chk("reset_e_key", longint'(e_key), 0);
    chk("reset_d_key", longint'(d_key), 0);
    rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      seq_n = v[i].n;
      for (int j = 0; j < 3; j++) seq_a[j] = v[i].s[j];
      run_check(longint'(v[i].phi), v[i].ok, longint'(v[i].e), longint'(v[i].d), v[i].rng, v[i].lat);
    end
    seq_n = 1; seq_a[0] = 17;
    @(negedge clk);
    phi = 3120; start = 1; base = pulses;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("busy_in_div", longint'(busy), 1);
    rst_n = 0;
    @(negedge clk);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_rng_en", longint'(rng_en), 0);
    chk("abort_e_key", longint'(e_key), 0);
    chk("abort_d_key", longint'(d_key), 0);
    chk("abort_pulses", longint'(key_valid | fail), 0);
    rst_n = 1;
    held_e = 0; held_d = 0; spur = 0;
    repeat (150) begin
      @(negedge clk);
      if (key_valid || fail || busy) spur++;
    end
    chk("abort_quiet", spur, 0);
    seq_a[0] = 7;
    run_check(20, 1, 7, 3, 1, 101);
    for (int i = 0; i < 20; i++) begin
      p = (i % 2 == 1) ? longint'($urandom_range(5, 200)) : longint'($urandom_range(5, 32'hFFFF_FFFF));
      seq_n = 4;
      for (int j = 0; j < 3; j++) seq_a[j] = (j == 0) ? $urandom : 32'(longint'($urandom) % p);
      seq_a[3] = ((p - 1) % 2 == 1) ? 32'(p - 1) : 32'(p - 2);
      model(p, m_ok, m_e, m_d, m_nc, m_lat);
      run_check(p, m_ok, m_e, m_d, m_nc, m_lat);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
